// File: rtl/param_step_cpu_pkg.sv
// Shared opcodes and instruction-field helpers for the step CPU.
package param_step_cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_MOV  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_INC  = 4'h7;
    localparam logic [3:0] OP_DEC  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'hA;
    localparam logic [3:0] OP_JNZ  = 4'hB;
    localparam logic [3:0] OP_JC   = 4'hC;
    localparam logic [3:0] OP_JNC  = 4'hD;
    localparam logic [3:0] OP_CALL = 4'hE;
    localparam logic [3:0] OP_RET  = 4'hF;

    function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Instruction layout, LSB first: imm, rs, rd, op.
    function automatic int unsigned rs_lsb(input int unsigned imm_w);
        return imm_w;
    endfunction

    function automatic int unsigned rd_lsb(input int unsigned rsel_w, input int unsigned imm_w);
        return imm_w + rsel_w;
    endfunction

    function automatic int unsigned op_lsb(input int unsigned rsel_w, input int unsigned imm_w);
        return imm_w + 2 * rsel_w;
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for opcodes ADD..DEC; result, zero and carry/borrow.
module cpu_alu
    import param_step_cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 4
) (
    input  logic [3:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zf_o,
    output logic              cf_o
);

    logic [DATA_W:0]   wide;
    logic [DATA_W-1:0] res;
    logic              cf;

    // Compute result and carry; the extra bit of 'wide' holds carry/borrow.
    always_comb begin
        res  = a_i;
        cf   = 1'b0;
        wide = '0;
        case (op_i)
            OP_ADD: begin
                wide = {1'b0, a_i} + {1'b0, b_i};
                res  = wide[DATA_W-1:0];
                cf   = wide[DATA_W];
            end
            OP_SUB: begin
                wide = {1'b0, a_i} - {1'b0, b_i};
                res  = wide[DATA_W-1:0];
                cf   = wide[DATA_W];
            end
            OP_AND: res = a_i & b_i;
            OP_XOR: res = a_i ^ b_i;
            OP_INC: begin
                res = a_i + DATA_W'(1);
                cf  = (res == '0);
            end
            OP_DEC: begin
                res = a_i - DATA_W'(1);
                cf  = &res;
            end
            default: ;
        endcase
    end

    assign result_o = res;
    assign cf_o     = cf;
    assign zf_o     = (res == '0);

endmodule

// File: rtl/param_step_cpu.sv
// Accumulator-style teaching CPU: register file, Z/C flags, return stack,
// one instruction per step pulse or continuous in run mode.
module param_step_cpu
    import param_step_cpu_pkg::*;
#(
    parameter int unsigned DATA_W      = 4,
    parameter int unsigned PC_W        = 4,
    parameter int unsigned NREGS       = 4,
    parameter int unsigned STACK_DEPTH = 2,
    localparam int unsigned RSEL_W     = $clog2(NREGS),
    localparam int unsigned IMM_W      = max_w(DATA_W, PC_W),
    localparam int unsigned INSTR_W    = 4 + 2 * RSEL_W + IMM_W,
    localparam int unsigned SP_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    step_req,
    input  logic                    run_mode,
    output logic [PC_W-1:0]         rom_addr,
    input  logic [INSTR_W-1:0]      rom_data,
    output logic [NREGS*DATA_W-1:0] regs_flat,
    output logic [PC_W-1:0]         pc,
    output logic                    zf,
    output logic                    cf,
    output logic                    halted,
    output logic                    fault,
    output logic [SP_W-1:0]         sp
);

    localparam int unsigned RD_LSB = rd_lsb(RSEL_W, IMM_W);
    localparam int unsigned RS_LSB = rs_lsb(IMM_W);
    localparam int unsigned OP_LSB = op_lsb(RSEL_W, IMM_W);
    localparam int unsigned STK_IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StExec = 2'd1;
    localparam logic [1:0] StStop = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              zf_q, zf_d, cf_q, cf_d;
    logic              halted_q, halted_d, fault_q, fault_d;
    logic [SP_W-1:0]   sp_q;
    logic [DATA_W-1:0] regs_q  [NREGS];
    logic [PC_W-1:0]   stack_q [STACK_DEPTH];

    logic [3:0]        op;
    logic [RSEL_W-1:0] rd_idx, rs_idx;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] imm_data, opa, opb, alu_res, reg_wdata;
    logic [PC_W-1:0]   target, pc_inc;
    logic              alu_zf, alu_cf, reg_we, push, pop, take, sp_full;
    logic [SP_W-1:0]   sp_dec;
    logic [STK_IW-1:0] push_idx, pop_idx;

    assign op       = rom_data[OP_LSB +: 4];
    assign rd_idx   = rom_data[RD_LSB +: RSEL_W];
    assign rs_idx   = rom_data[RS_LSB +: RSEL_W];
    assign imm      = rom_data[IMM_W-1:0];
    // Immediate bits above the data/pc width are simply dropped.
    assign imm_data = imm[DATA_W-1:0];
    assign target   = imm[PC_W-1:0];
    assign opa      = regs_q[rd_idx];
    assign opb      = regs_q[rs_idx];
    assign pc_inc   = pc_q + PC_W'(1);
    assign sp_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign sp_dec   = sp_q - SP_W'(1);
    assign push_idx = sp_q[STK_IW-1:0];
    assign pop_idx  = sp_dec[STK_IW-1:0];

    cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op_i     (op),
        .a_i      (opa),
        .b_i      (opb),
        .result_o (alu_res),
        .zf_o     (alu_zf),
        .cf_o     (alu_cf)
    );

    // Sequencing and execute: all architectural updates resolved here, committed in EXEC.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        zf_d      = zf_q;
        cf_d      = cf_q;
        halted_d  = halted_q;
        fault_d   = fault_q;
        reg_we    = 1'b0;
        reg_wdata = alu_res;
        push      = 1'b0;
        pop       = 1'b0;
        take      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (run_mode || step_req) state_d = StExec;
            end
            StExec: begin
                state_d = StIdle;
                pc_d    = pc_inc;
                case (op)
                    OP_LDI: begin
                        reg_we    = 1'b1;
                        reg_wdata = imm_data;
                    end
                    OP_MOV: begin
                        reg_we    = 1'b1;
                        reg_wdata = opb;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_INC, OP_DEC: begin
                        reg_we = 1'b1;
                        zf_d   = alu_zf;
                        cf_d   = alu_cf;
                    end
                    OP_JMP, OP_CALL: take = 1'b1;
                    OP_JZ:           take = zf_q;
                    OP_JNZ:          take = ~zf_q;
                    OP_JC:           take = cf_q;
                    OP_JNC:          take = ~cf_q;
                    OP_RET: begin
                        if (sp_q == '0) begin
                            pc_d    = pc_q;
                            fault_d = 1'b1;
                            state_d = StStop;
                        end else begin
                            pop  = 1'b1;
                            pc_d = stack_q[pop_idx];
                        end
                    end
                    default: ;
                endcase
                // Only taken transfers can halt; an untaken self-jump falls through.
                if (take) begin
                    if (target == pc_q) begin
                        pc_d     = pc_q;
                        halted_d = 1'b1;
                        state_d  = StStop;
                    end else if (op == OP_CALL && sp_full) begin
                        pc_d    = pc_q;
                        fault_d = 1'b1;
                        state_d = StStop;
                    end else begin
                        pc_d = target;
                        push = (op == OP_CALL);
                    end
                end
            end
            StStop: ;
            default: state_d = StIdle;
        endcase
    end

    // Architectural state and FSM registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            pc_q     <= '0;
            zf_q     <= 1'b0;
            cf_q     <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            zf_q     <= zf_d;
            cf_q     <= cf_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

    // Register file write port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
        end else if (reg_we) begin
            regs_q[rd_idx] <= reg_wdata;
        end
    end

    // Return stack: push stores the return address at sp, pop reads sp-1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sp_q <= '0;
            for (int s = 0; s < STACK_DEPTH; s++) stack_q[s] <= '0;
        end else if (push) begin
            stack_q[push_idx] <= pc_inc;
            sp_q              <= sp_q + SP_W'(1);
        end else if (pop) begin
            sp_q <= sp_dec;
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
    end

    assign rom_addr = pc_q;
    assign pc       = pc_q;
    assign zf       = zf_q;
    assign cf       = cf_q;
    assign halted   = halted_q;
    assign fault    = fault_q;
    assign sp       = sp_q;

endmodule
